pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 86 ++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection with flag-conditioned branches and a return-address stack
module pc_sequencer #(
    parameter int STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [2:0]  pc_op,
    input  logic [11:0] target,
    input  logic        flag_we,
    input  logic        zero_in,
    input  logic        cout_in,
    output logic [11:0] pc,
    output logic        z_flag,
    output logic        c_flag,
    output logic [4:0]  stack_depth,
    output logic        stack_err
);
    localparam int AW = $clog2(STACK_DEPTH);

    logic [11:0]   stack [STACK_DEPTH];
    logic [11:0]   pc_inc;
    logic [11:0]   nxt_pc;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          take;
    logic          push;
    logic          pop;
    logic          err;

    assign pc_inc = pc + 12'd1;
    assign wr_ptr = stack_depth[AW-1:0];
    assign rd_ptr = wr_ptr - AW'(1);
    assign full   = stack_depth == 5'(STACK_DEPTH);
    assign empty  = stack_depth == 5'd0;
    // odd branch encodings invert the tested flag; op[2] picks carry over zero
    assign take   = pc_op[0] ^ (pc_op[2] ? c_flag : z_flag);

    always_comb begin
        nxt_pc = pc_inc;
        push   = 1'b0;
        pop    = 1'b0;
        err    = 1'b0;
        case (pc_op)
            3'b000: nxt_pc = pc_inc;
            3'b001: nxt_pc = target;
            3'b110: begin
                nxt_pc = full ? pc_inc : target;
                push   = !full;
                err    = full;
            end
            3'b111: begin
                nxt_pc = empty ? pc_inc : stack[rd_ptr];
                pop    = !empty;
                err    = empty;
            end
            default: nxt_pc = take ? target : pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= 12'h000;
            z_flag      <= 1'b0;
            c_flag      <= 1'b0;
            stack_depth <= 5'd0;
            stack_err   <= 1'b0;
        end else if (!stall) begin
            pc <= nxt_pc;
            if (flag_we) begin
                z_flag <= zero_in;
                c_flag <= cout_in;
            end
            if (push) stack_depth <= stack_depth + 5'd1;
            if (pop) stack_depth <= stack_depth - 5'd1;
            if (err) stack_err <= 1'b1;
        end
    end

    // entries are invalidated by stack_depth, so the array itself needs no reset
    always_ff @(posedge clk) begin
        if (!rst && !stall && push) stack[wr_ptr] <= pc_inc;
    end
endmodule
